// File: rtl/axi_lite_apb_bridge_mslv.sv
// AXI4-Lite slave to APB4 master bridge with NUM_SLV address-decoded targets,
// round-robin read/write arbitration, DECERR for unmapped windows and a PREADY watchdog.
module axi_lite_apb_bridge_mslv #(
   parameter int ADDR_W       = 32,
   parameter int DATA_W       = 32,
   parameter int NUM_SLV      = 4,
   parameter int SLV_WIN_BITS = 12,
   parameter int TIMEOUT      = 256
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [ADDR_W-1:0]         s_awaddr,
   input  logic [2:0]                s_awprot,
   input  logic                      s_awvalid,
   output logic                      s_awready,
   input  logic [DATA_W-1:0]         s_wdata,
   input  logic [DATA_W/8-1:0]       s_wstrb,
   input  logic                      s_wvalid,
   output logic                      s_wready,
   output logic [1:0]                s_bresp,
   output logic                      s_bvalid,
   input  logic                      s_bready,
   input  logic [ADDR_W-1:0]         s_araddr,
   input  logic [2:0]                s_arprot,
   input  logic                      s_arvalid,
   output logic                      s_arready,
   output logic [DATA_W-1:0]         s_rdata,
   output logic [1:0]                s_rresp,
   output logic                      s_rvalid,
   input  logic                      s_rready,
   output logic [ADDR_W-1:0]         paddr,
   output logic [NUM_SLV-1:0]        psel,
   output logic                      penable,
   output logic                      pwrite,
   output logic [DATA_W-1:0]         pwdata,
   output logic [DATA_W/8-1:0]       pstrb,
   output logic [2:0]                pprot,
   input  logic [NUM_SLV*DATA_W-1:0] prdata,
   input  logic [NUM_SLV-1:0]        pready,
   input  logic [NUM_SLV-1:0]        pslverr
);

   localparam int STRB_W  = DATA_W / 8;
   localparam int IDX_W   = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
   localparam int CNT_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam int TO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   typedef enum logic [2:0] {IDLE, SETUP, ACCESS, WRESP, RRESP} state_e;

   state_e              state_q, state_d;
   logic                last_wr_q, last_wr_d;
   logic                is_wr_q, is_wr_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [2:0]          prot_q, prot_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [STRB_W-1:0]   strb_q, strb_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [1:0]          resp_q, resp_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;

   logic                wr_pend, rd_pend, sel_wr, sel_rd;
   logic [ADDR_W-1:0]   acc_addr;
   logic [IDX_W-1:0]    acc_idx;
   logic                acc_bad;
   logic [NUM_SLV-1:0]  slv_sel;
   logic                slv_ready, slv_err;
   logic [DATA_W-1:0]   slv_rdata;
   logic                apb_act, timeout_hit;

   // With both kinds pending, serve whichever kind did not go last.
   assign wr_pend  = s_awvalid && s_wvalid;
   assign rd_pend  = s_arvalid;
   assign sel_wr   = wr_pend && (!rd_pend || !last_wr_q);
   assign sel_rd   = rd_pend && !sel_wr;
   assign acc_addr = sel_wr ? s_awaddr : s_araddr;
   assign acc_idx  = acc_addr[SLV_WIN_BITS +: IDX_W];
   assign acc_bad  = ({1'b0, acc_idx} >= (IDX_W + 1)'(NUM_SLV));

   assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_W'(TO_LAST));

   always_comb begin
      slv_sel   = '0;
      slv_ready = 1'b0;
      slv_err   = 1'b0;
      slv_rdata = '0;
      for (int i = 0; i < NUM_SLV; i++) begin
         if (idx_q == IDX_W'(i)) begin
            slv_sel[i] = 1'b1;
            slv_ready  = pready[i];
            slv_err    = pslverr[i];
            slv_rdata  = prdata[i*DATA_W +: DATA_W];
         end
      end
   end

   // NOTE: every signal written here gets a default first, so no path can infer a latch.
   always_comb begin
      state_d   = state_q;
      last_wr_d = last_wr_q;
      is_wr_d   = is_wr_q;
      addr_d    = addr_q;
      prot_d    = prot_q;
      wdata_d   = wdata_q;
      strb_d    = strb_q;
      idx_d     = idx_q;
      resp_d    = resp_q;
      rdata_d   = rdata_q;
      cnt_d     = cnt_q;
      s_awready = 1'b0;
      s_wready  = 1'b0;
      s_arready = 1'b0;
      case (state_q)
         IDLE: begin
            if (!rst && (sel_wr || sel_rd)) begin
               s_awready = sel_wr;
               s_wready  = sel_wr;
               s_arready = sel_rd;
               is_wr_d   = sel_wr;
               addr_d    = acc_addr;
               prot_d    = sel_wr ? s_awprot : s_arprot;
               wdata_d   = sel_wr ? s_wdata : '0;
               strb_d    = sel_wr ? s_wstrb : '0;
               idx_d     = acc_idx;
               rdata_d   = '0;
               cnt_d     = '0;
               if (acc_bad) begin
                  resp_d  = RESP_DECERR;
                  state_d = sel_wr ? WRESP : RRESP;
               end else begin
                  resp_d  = RESP_OKAY;
                  state_d = SETUP;
               end
            end
         end
         SETUP: begin
            cnt_d   = '0;
            state_d = ACCESS;
         end
         ACCESS: begin
            if (slv_ready) begin
               resp_d  = slv_err ? RESP_SLVERR : RESP_OKAY;
               rdata_d = (is_wr_q || slv_err) ? '0 : slv_rdata;
               state_d = is_wr_q ? WRESP : RRESP;
            end else if (timeout_hit) begin
               resp_d  = RESP_SLVERR;
               rdata_d = '0;
               state_d = is_wr_q ? WRESP : RRESP;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         WRESP: begin
            if (s_bready) begin
               last_wr_d = 1'b1;
               state_d   = IDLE;
            end
         end
         RRESP: begin
            if (s_rready) begin
               last_wr_d = 1'b0;
               state_d   = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         last_wr_q <= 1'b0;
         is_wr_q   <= 1'b0;
         addr_q    <= '0;
         prot_q    <= '0;
         wdata_q   <= '0;
         strb_q    <= '0;
         idx_q     <= '0;
         resp_q    <= '0;
         rdata_q   <= '0;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         last_wr_q <= last_wr_d;
         is_wr_q   <= is_wr_d;
         addr_q    <= addr_d;
         prot_q    <= prot_d;
         wdata_q   <= wdata_d;
         strb_q    <= strb_d;
         idx_q     <= idx_d;
         resp_q    <= resp_d;
         rdata_q   <= rdata_d;
         cnt_q     <= cnt_d;
      end
   end

   // APB and response outputs are gated by state so an abort or idle bus reads as all zero.
   assign apb_act  = (state_q == SETUP) || (state_q == ACCESS);
   assign psel     = apb_act ? slv_sel : '0;
   assign penable  = (state_q == ACCESS);
   assign pwrite   = apb_act && is_wr_q;
   assign paddr    = apb_act ? addr_q : '0;
   assign pwdata   = apb_act ? wdata_q : '0;
   assign pstrb    = apb_act ? strb_q : '0;
   assign pprot    = apb_act ? prot_q : '0;
   assign s_bvalid = (state_q == WRESP);
   assign s_bresp  = s_bvalid ? resp_q : '0;
   assign s_rvalid = (state_q == RRESP);
   assign s_rresp  = s_rvalid ? resp_q : '0;
   assign s_rdata  = s_rvalid ? rdata_q : '0;

endmodule

// File: tb/tb_axi_lite_apb_bridge_mslv.sv
// Directed bench for axi_lite_apb_bridge_mslv: a 4-slave instance with TIMEOUT=8
// and a 3-slave instance for the unmapped-window DECERR path.
module tb_axi_lite_apb_bridge_mslv;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;
   int n_fail = 0;

   // 4-slave instance
   logic [31:0]  awaddr, wdata, araddr, rdata, paddr, pwdata;
   logic [2:0]   awprot, arprot, pprot;
   logic [3:0]   wstrb, pstrb, psel, pready, pslverr;
   logic [1:0]   bresp, rresp;
   logic         awvalid, awready, wvalid, wready, bvalid, bready;
   logic         arvalid, arready, rvalid, rready, penable, pwrite;
   logic [127:0] prdata;

   // 3-slave instance
   logic [31:0]  d3_awaddr, d3_wdata, d3_araddr, d3_rdata, d3_paddr, d3_pwdata;
   logic [2:0]   d3_awprot, d3_arprot, d3_pprot, d3_psel, d3_pready, d3_pslverr;
   logic [3:0]   d3_wstrb, d3_pstrb;
   logic [1:0]   d3_bresp, d3_rresp;
   logic         d3_awvalid, d3_awready, d3_wvalid, d3_wready, d3_bvalid, d3_bready;
   logic         d3_arvalid, d3_arready, d3_rvalid, d3_rready, d3_penable, d3_pwrite;
   logic [95:0]  d3_prdata;

   axi_lite_apb_bridge_mslv #(
      .ADDR_W(32), .DATA_W(32), .NUM_SLV(4), .SLV_WIN_BITS(12), .TIMEOUT(8)
   ) u_dut (
      .clk(clk), .rst(rst),
      .s_awaddr(awaddr), .s_awprot(awprot), .s_awvalid(awvalid), .s_awready(awready),
      .s_wdata(wdata), .s_wstrb(wstrb), .s_wvalid(wvalid), .s_wready(wready),
      .s_bresp(bresp), .s_bvalid(bvalid), .s_bready(bready),
      .s_araddr(araddr), .s_arprot(arprot), .s_arvalid(arvalid), .s_arready(arready),
      .s_rdata(rdata), .s_rresp(rresp), .s_rvalid(rvalid), .s_rready(rready),
      .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite),
      .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot),
      .prdata(prdata), .pready(pready), .pslverr(pslverr)
   );

   axi_lite_apb_bridge_mslv #(
      .ADDR_W(32), .DATA_W(32), .NUM_SLV(3), .SLV_WIN_BITS(12), .TIMEOUT(8)
   ) u_dut3 (
      .clk(clk), .rst(rst),
      .s_awaddr(d3_awaddr), .s_awprot(d3_awprot), .s_awvalid(d3_awvalid), .s_awready(d3_awready),
      .s_wdata(d3_wdata), .s_wstrb(d3_wstrb), .s_wvalid(d3_wvalid), .s_wready(d3_wready),
      .s_bresp(d3_bresp), .s_bvalid(d3_bvalid), .s_bready(d3_bready),
      .s_araddr(d3_araddr), .s_arprot(d3_arprot), .s_arvalid(d3_arvalid), .s_arready(d3_arready),
      .s_rdata(d3_rdata), .s_rresp(d3_rresp), .s_rvalid(d3_rvalid), .s_rready(d3_rready),
      .paddr(d3_paddr), .psel(d3_psel), .penable(d3_penable), .pwrite(d3_pwrite),
      .pwdata(d3_pwdata), .pstrb(d3_pstrb), .pprot(d3_pprot),
      .prdata(d3_prdata), .pready(d3_pready), .pslverr(d3_pslverr)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge; inputs are driven here.
   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   int n_acc, n_double, n_split, n_pen;
   logic [3:0] seq;

   initial begin
      rst = 1'b1;
      awaddr = '0; awprot = '0; wdata = '0; wstrb = '0; bready = 1'b0;
      araddr = '0; arprot = '0; rready = 1'b0;
      prdata = '0; pready = '0; pslverr = '0;
      awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
      d3_awaddr = '0; d3_awprot = '0; d3_awvalid = 1'b0; d3_wdata = '0; d3_wstrb = '0;
      d3_wvalid = 1'b0; d3_bready = 1'b0; d3_araddr = '0; d3_arprot = '0;
      d3_arvalid = 1'b0; d3_rready = 1'b0; d3_prdata = '0; d3_pready = '0; d3_pslverr = '0;

      // Reset: readies held low despite valids, every output zero
      cyc(); cyc(); #1;
      check("rst_awready", awready, 0);
      check("rst_arready", arready, 0);
      check("rst_psel", psel, 0);
      check("rst_penable", penable, 0);
      check("rst_paddr", paddr, 0);
      check("rst_bvalid", bvalid, 0);
      check("rst_rvalid", rvalid, 0);
      awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
      rst = 1'b0;

      // Write 0xDEADBEEF to slave 1, zero-wait
      cyc();
      awaddr = 32'h0000_1004; awprot = 3'b010; wdata = 32'hDEAD_BEEF; wstrb = 4'hF;
      awvalid = 1'b1; wvalid = 1'b1; pready = 4'b1111;
      #1;
      check("wr_awready", awready, 1);
      check("wr_wready", wready, 1);
      check("wr_arready", arready, 0);
      cyc(); awvalid = 1'b0; wvalid = 1'b0; #1;
      check("wr_setup_psel", psel, 4'b0010);
      check("wr_setup_penable", penable, 0);
      check("wr_setup_pwrite", pwrite, 1);
      check("wr_setup_paddr", paddr, 32'h0000_1004);
      check("wr_setup_pwdata", pwdata, 32'hDEAD_BEEF);
      check("wr_setup_pstrb", pstrb, 4'hF);
      check("wr_setup_pprot", pprot, 3'b010);
      cyc(); #1;
      check("wr_access_psel", psel, 4'b0010);
      check("wr_access_penable", penable, 1);
      check("wr_access_bvalid", bvalid, 0);
      cyc(); #1;
      check("wr_bvalid_t3", bvalid, 1);
      check("wr_bresp", bresp, 2'b00);
      check("wr_psel_drop", psel, 0);
      cyc(); #1;
      check("wr_bvalid_hold", bvalid, 1);
      bready = 1'b1;
      cyc(); #1;
      check("wr_bvalid_done", bvalid, 0);

      // Read slave 3 with two wait states; other slaves ready but ignored
      cyc();
      araddr = 32'h0000_3010; arprot = 3'b101; arvalid = 1'b1; rready = 1'b1;
      pready = 4'b0111;
      prdata[3*32 +: 32] = 32'h1234_5678;
      prdata[0*32 +: 32] = 32'hAAAA_5555;
      #1;
      check("rd_arready", arready, 1);
      check("rd_awready", awready, 0);
      cyc(); arvalid = 1'b0; #1;
      check("rd_setup_psel", psel, 4'b1000);
      check("rd_setup_penable", penable, 0);
      check("rd_setup_pwrite", pwrite, 0);
      check("rd_setup_paddr", paddr, 32'h0000_3010);
      check("rd_setup_pprot", pprot, 3'b101);
      check("rd_setup_pstrb", pstrb, 0);
      cyc(); #1;
      check("rd_wait1_penable", penable, 1);
      cyc(); #1;
      check("rd_wait2_penable", penable, 1);
      check("rd_wait2_rvalid", rvalid, 0);
      cyc(); pready = 4'b1111; #1;
      check("rd_last_penable", penable, 1);
      cyc(); #1;
      check("rd_rvalid_t5", rvalid, 1);
      check("rd_rdata", rdata, 32'h1234_5678);
      check("rd_rresp", rresp, 2'b00);
      check("rd_psel_drop", psel, 0);

      // Simultaneous write and read requests held for 16 cycles: W,R,W,R
      cyc();
      awaddr = 32'h0000_0000; wdata = 32'h0000_0011; wstrb = 4'hF;
      araddr = 32'h0000_0004; prdata[0 +: 32] = 32'h0A0B_0C0D;
      awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
      n_acc = 0; n_double = 0; n_split = 0; seq = '0;
      for (int i = 0; i < 16; i++) begin
         #1;
         if (awready != wready) n_split++;
         if (awready && arready) n_double++;
         if (awready || arready) begin
            n_acc++;
            seq = {seq[2:0], awready};
         end
         cyc();
      end
      awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
      check("arb_accepts", n_acc, 4);
      check("arb_order_wrwr", seq, 4'b1010);
      check("arb_double_ready", n_double, 0);
      check("arb_aw_w_split", n_split, 0);

      // Watchdog: slave 0 never ready, ACCESS lasts exactly 8 cycles
      awaddr = 32'h0000_0008; wdata = 32'h55AA_55AA; awvalid = 1'b1; wvalid = 1'b1;
      pready = 4'b1110;
      #1;
      check("to_awready", awready, 1);
      cyc(); awvalid = 1'b0; wvalid = 1'b0; #1;
      check("to_setup_psel", psel, 4'b0001);
      cyc(); #1;
      n_pen = 0;
      for (int i = 0; i < 20; i++) begin
         if (!penable) break;
         n_pen++;
         cyc(); #1;
      end
      check("to_access_cycles", n_pen, 8);
      check("to_bvalid", bvalid, 1);
      check("to_bresp", bresp, 2'b10);
      check("to_psel_drop", psel, 0);

      // PSLVERR on a read: SLVERR, data zeroed
      cyc();
      araddr = 32'h0000_2000; arvalid = 1'b1; pready = 4'b1111; pslverr = 4'b0100;
      prdata[2*32 +: 32] = 32'hCAFE_F00D;
      #1;
      check("err_arready", arready, 1);
      cyc(); arvalid = 1'b0;
      cyc(); cyc(); #1;
      check("err_rvalid", rvalid, 1);
      check("err_rresp", rresp, 2'b10);
      check("err_rdata", rdata, 0);

      // PSLVERR of an unselected slave is ignored
      cyc();
      araddr = 32'h0000_1000; arvalid = 1'b1;
      prdata[1*32 +: 32] = 32'h600D_F00D;
      cyc(); arvalid = 1'b0;
      cyc(); cyc(); #1;
      check("oth_err_rvalid", rvalid, 1);
      check("oth_err_rresp", rresp, 2'b00);
      check("oth_err_rdata", rdata, 32'h600D_F00D);

      // NUM_SLV=3: window 3 is unmapped
      cyc();
      d3_araddr = 32'h0000_3000; d3_arvalid = 1'b1; d3_rready = 1'b1;
      d3_pready = 3'b111; d3_prdata = {3{32'hFFFF_FFFF}};
      #1;
      check("dec_arready", d3_arready, 1);
      cyc(); d3_arvalid = 1'b0; #1;
      check("dec_rvalid_t1", d3_rvalid, 1);
      check("dec_rresp", d3_rresp, 2'b11);
      check("dec_rdata", d3_rdata, 0);
      check("dec_psel", d3_psel, 0);
      cyc(); #1;
      check("dec_rvalid_done", d3_rvalid, 0);

      // Reset pulse mid-ACCESS aborts with no response
      cyc();
      awaddr = 32'h0000_1000; wdata = 32'h0000_0077; awvalid = 1'b1; wvalid = 1'b1;
      pready = 4'b0000; pslverr = 4'b0000;
      #1;
      check("abt_awready", awready, 1);
      cyc(); awvalid = 1'b0; wvalid = 1'b0;
      cyc(); #1;
      check("abt_in_access", penable, 1);
      rst = 1'b1;
      cyc(); #1;
      check("abt_psel", psel, 0);
      check("abt_penable", penable, 0);
      check("abt_paddr", paddr, 0);
      check("abt_pwrite", pwrite, 0);
      check("abt_pwdata", pwdata, 0);
      check("abt_bvalid", bvalid, 0);
      rst = 1'b0; pready = 4'b1111;
      cyc(); cyc(); #1;
      check("abt_no_late_bvalid", bvalid, 0);
      araddr = 32'h0000_1008; arvalid = 1'b1;
      prdata[1*32 +: 32] = 32'h0BAD_F00D;
      #1;
      check("post_rst_arready", arready, 1);
      cyc(); arvalid = 1'b0;
      cyc(); cyc(); #1;
      check("post_rst_rvalid", rvalid, 1);
      check("post_rst_rdata", rdata, 32'h0BAD_F00D);
      check("post_rst_rresp", rresp, 2'b00);

      cyc(); cyc();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
